// File: rtl/keypad_scan_pkg.sv
// -----------------------------------------------------------------------------
// keypad_defs: shared constants and helpers for the keypad scanner. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package keypad_defs;

  localparam logic [1:0] c_st_scan     = 2'd0;
  localparam logic [1:0] c_st_debounce = 2'd1;
  localparam logic [1:0] c_st_hold     = 2'd2;

  localparam int c_def_scan_div     = 50000;
  localparam int c_def_debounce_cnt = 4;

  localparam int c_row_w  = 2;
  localparam int c_col_w  = 2;
  localparam int c_code_w = c_row_w + c_col_w;
  localparam int c_cnt_w  = 4;

  // Lowest-index active-low row; other simultaneous rows are ignored.
  function automatic logic [c_row_w-1:0] lowest_low(input logic [3:0] rows);
    logic [c_row_w-1:0] idx;
    idx = '0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = c_row_w'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_scan_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff: generic N-bit two-flop synchronizer, resets to all ones. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule

`default_nettype wire

// File: rtl/keypad_scan.sv
// -----------------------------------------------------------------------------
// keypad_scan: 4x4 active-low matrix keypad scanner with press/release debounce. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module keypad_scan
  import keypad_defs::*;
#(
  parameter int SCAN_DIV     = c_def_scan_div,
  parameter int DEBOUNCE_CNT = c_def_debounce_cnt
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [3:0]          row_i,
  output logic [3:0]          col_o,
  output logic [c_code_w-1:0] keyboard_val_o,
  output logic                key_pressed_o,
  output logic                key_strobe_o
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0]   c_div_last = DIV_W'(SCAN_DIV - 1);
  localparam logic [c_cnt_w-1:0] c_deb_last = c_cnt_w'(DEBOUNCE_CNT - 1);

  logic [3:0]          w_rows_s;
  logic [DIV_W-1:0]    r_div;
  logic [1:0]          r_state;
  logic [1:0]          w_state_next;
  logic [c_col_w-1:0]  r_col_idx;
  logic [c_code_w-1:0] r_cand;
  logic [c_code_w-1:0] r_val;
  logic [c_cnt_w-1:0]  r_match;
  logic [c_cnt_w-1:0]  r_rel;
  logic                r_strobe;

  logic                w_sample;
  logic                w_hit;
  logic [c_code_w-1:0] w_code;
  logic                w_advance;
  logic                w_start;
  logic                w_match_inc;
  logic                w_accept;
  logic                w_rel_inc;
  logic                w_rel_clr;

  sync_2ff #(
    .WIDTH (4)
  ) u_row_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (row_i),
    .q_o     (w_rows_s)
  );

  assign w_sample = (r_div == c_div_last);
  assign w_hit    = ~&w_rows_s;
  assign w_code   = {lowest_low(w_rows_s), r_col_idx};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_div <= '0;
    end else if (w_sample) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= c_st_scan;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Every decision is taken only on a sample cycle; between samples the FSM idles.
  always_comb begin
    w_state_next = r_state;
    w_advance    = 1'b0;
    w_start      = 1'b0;
    w_match_inc  = 1'b0;
    w_accept     = 1'b0;
    w_rel_inc    = 1'b0;
    w_rel_clr    = 1'b0;
    case (r_state)
      c_st_scan: begin
        if (w_sample) begin
          if (w_hit) begin
            w_start      = 1'b1;
            w_state_next = c_st_debounce;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      c_st_debounce: begin
        if (w_sample) begin
          if (w_hit && (w_code == r_cand)) begin
            if (r_match == c_deb_last) begin
              w_accept     = 1'b1;
              w_state_next = c_st_hold;
            end else begin
              w_match_inc = 1'b1;
            end
          end else begin
            w_advance    = 1'b1;
            w_state_next = c_st_scan;
          end
        end
      end
      c_st_hold: begin
        if (w_sample) begin
          if (w_hit) begin
            w_rel_clr = 1'b1;
          end else if (r_rel == c_deb_last) begin
            w_advance    = 1'b1;
            w_state_next = c_st_scan;
          end else begin
            w_rel_inc = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = c_st_scan;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_col_idx <= '0;
      r_cand    <= '0;
      r_val     <= '0;
      r_match   <= '0;
      r_rel     <= '0;
      r_strobe  <= 1'b0;
    end else begin
      r_strobe <= w_accept;
      if (w_advance) begin
        r_col_idx <= r_col_idx + c_col_w'(1);
      end
      if (w_start) begin
        r_cand  <= w_code;
        r_match <= c_cnt_w'(1);
      end else if (w_match_inc) begin
        r_match <= r_match + c_cnt_w'(1);
      end else if (w_accept || w_advance) begin
        r_match <= '0;
      end
      if (w_accept) begin
        r_val <= r_cand;
      end
      if (w_rel_inc) begin
        r_rel <= r_rel + c_cnt_w'(1);
      end else if (w_rel_clr || w_advance || w_accept) begin
        r_rel <= '0;
      end
    end
  end

  always_comb begin
    col_o          = ~(4'b0001 << r_col_idx);
    keyboard_val_o = r_val;
    key_pressed_o  = (r_state == c_st_hold);
    key_strobe_o   = r_strobe;
  end

endmodule

`default_nettype wire

// File: tb/tb_keypad_scan.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan: scoreboard bench for keypad_scan with a matrix keypad model. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_keypad_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] row_i;
  logic [3:0] col_o;
  logic [3:0] val;
  logic       pressed;
  logic       strobe;
  logic [15:0] key_down;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;

  typedef struct {
    logic [3:0] code;
    int         cyc;
    logic [3:0] col;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  keypad_scan #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (3)
  ) dut (
    .clk_i          (clk),
    .reset_i        (rst),
    .row_i          (row_i),
    .col_o          (col_o),
    .keyboard_val_o (val),
    .key_pressed_o  (pressed),
    .key_strobe_o   (strobe)
  );

  // A row reads low when any held key on it sits on a column driven low.
  always_comb begin
    row_i = 4'hF;
    for (int r = 0; r < 4; r++) begin
      row_i[r] = ~|(key_down[r*4 +: 4] & ~col_o);
    end
  end

  function automatic logic [3:0] colmask(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && strobe) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", strobe, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("strobe_code", val, e.code);
        chk("strobe_cycle", cyc, e.cyc);
        chk("strobe_pressed", pressed, 1);
        chk("strobe_col", col_o, e.col);
      end
    end
  end

  // Returns at the first negedge after the scan has just moved onto column c.
  task automatic wait_col(input int c);
    int n;
    n = 0;
    while (col_o == colmask(c) && n < 40) begin
      @(negedge clk);
      n++;
    end
    while (col_o != colmask(c) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      failures++;
      $display("FAIL wait_col actual=%b expected=%b", col_o, colmask(c));
    end
  endtask

  task automatic wait_release(input string name);
    int n;
    n = 0;
    while (pressed && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(name, pressed, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc0;
    rst      = 1'b1;
    key_down = '0;
    repeat (3) @(negedge clk);
    chk("rst_col", col_o, 4'b1110);
    chk("rst_val", val, 0);
    chk("rst_pressed", pressed, 0);
    chk("rst_strobe", strobe, 0);

    // Idle scan: column index advances every 4 cycles.
    rst = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      chk("idle_col", col_o, colmask((n / 4) % 4));
    end
    chk("idle_val", val, 0);

    // Row 2 / column 1 held.
    wait_col(1);
    cyc0 = cyc;
    key_down[2*4+1] = 1'b1;
    sb.push_back('{4'h9, cyc0 + 12, colmask(1)});
    repeat (13) @(negedge clk);
    chk("k9_strobe_seen", sb.size(), 0);
    repeat (8) @(negedge clk);
    chk("k9_held_pressed", pressed, 1);
    chk("k9_held_col", col_o, colmask(1));
    key_down = '0;
    wait_release("k9_release");
    chk("k9_release_col", col_o, colmask(2));

    // Bounce: seen on two samples only.
    wait_col(0);
    key_down[1*4+0] = 1'b1;
    repeat (8) @(negedge clk);
    key_down = '0;
    repeat (4) @(negedge clk);
    chk("bounce_col", col_o, colmask(1));
    chk("bounce_pressed", pressed, 0);
    chk("bounce_val", val, 4'h9);

    // Held key with a one-sample re-bounce during release.
    wait_col(2);
    cyc0 = cyc;
    key_down[3*4+2] = 1'b1;
    sb.push_back('{4'hE, cyc0 + 12, colmask(2)});
    repeat (12) @(negedge clk);
    key_down = '0;
    @(negedge clk);
    chk("ke_strobe_seen", sb.size(), 0);
    repeat (3) @(negedge clk);
    key_down[3*4+2] = 1'b1;
    repeat (4) @(negedge clk);
    key_down = '0;
    chk("rebounce_pressed_n20", pressed, 1);
    repeat (11) @(negedge clk);
    chk("rebounce_pressed_n31", pressed, 1);
    @(negedge clk);
    chk("rebounce_pressed_n32", pressed, 0);
    chk("rebounce_col_n32", col_o, colmask(3));

    // Rows 1 and 3 on column 3: lowest row wins.
    wait_col(3);
    cyc0 = cyc;
    key_down[1*4+3] = 1'b1;
    key_down[3*4+3] = 1'b1;
    sb.push_back('{4'h7, cyc0 + 12, colmask(3)});
    repeat (16) @(negedge clk);
    chk("k7_strobe_seen", sb.size(), 0);
    chk("k7_hold_pressed", pressed, 1);
    chk("k7_hold_col", col_o, colmask(3));

    // Reset in HOLD.
    rst = 1'b1;
    #1;
    chk("midrst_col", col_o, 4'b1110);
    chk("midrst_val", val, 0);
    chk("midrst_pressed", pressed, 0);
    chk("midrst_strobe", strobe, 0);
    key_down = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Press after reset strobes normally.
    wait_col(2);
    cyc0 = cyc;
    key_down[0*4+2] = 1'b1;
    sb.push_back('{4'h2, cyc0 + 12, colmask(2)});
    repeat (13) @(negedge clk);
    chk("k2_strobe_seen", sb.size(), 0);
    key_down = '0;
    wait_release("k2_release");

    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/keypad_scan.md
# keypad_scan

Scans a 4x4 active-low matrix keypad, debounces presses, and presents a stable 4-bit key code plus press status to the I/O interface block. The key code drives that block's `keyboard_val_i`. The block sits between the board keypad pins and the I/O interface in the top-level wrapper. It owns column drive, row sampling, debounce and release detection.

## Interface
Parameters:
- `SCAN_DIV`, default 50000: clock cycles each column is driven (dwell); legal minimum 4.
- `DEBOUNCE_CNT`, default 4: consecutive identical samples required to accept a press or a release; legal range 2..15.

Ports:
- `clk_i`  in  1  system clock.
- `reset_i`  in  1  reset. One clock; reset is asynchronous and active-high.
- `row_i`  in  4  keypad rows; asynchronous to `clk_i`; pulled up; low = key closed on the driven column.
- `col_o`  out  4  column drive, active-low one-hot; exactly one bit low at all times.
- `keyboard_val_o`  out  4  code of the last accepted key, `{row_idx[1:0], col_idx[1:0]}`; holds its value until the next accepted press.
- `key_pressed_o`  out  1  high while an accepted key is held.
- `key_strobe_o`  out  1  one-cycle pulse when a press is accepted.

## Operation
- `row_i` passes through a 2-flop synchronizer. The sampled row value is `rows_s`.
- A divider counter counts 0..SCAN_DIV-1 and wraps. A sample is taken in the cycle where the divider equals SCAN_DIV-1.
- Row decode: `hit` = any bit of `rows_s` low. `row_idx` = lowest-index low row; other simultaneous rows are ignored.
- FSM states and transitions:
  - SCAN
    - On a sample with no hit: advance the column to (col_idx+1) mod 4 and stay in SCAN.
    - On a sample with a hit: latch the candidate code, set match count to 1, go to DEBOUNCE. The column stays on the current one.
  - DEBOUNCE (column frozen)
    - On a sample whose code equals the candidate: increment the match count.
    - When the count reaches DEBOUNCE_CNT: load `keyboard_val_o`, pulse `key_strobe_o`, go to HOLD.
    - On a sample with no hit or a different code: advance the column, go to SCAN. `keyboard_val_o` is unchanged.
  - HOLD (column frozen, `key_pressed_o`=1)
    - Each no-hit sample increments the release count.
    - Any hit sample clears the release count, whichever key is sampled; no new strobe is issued.
    - When the release count reaches DEBOUNCE_CNT: clear `key_pressed_o`, advance the column, go to SCAN.
- `key_strobe_o` never stays high for two consecutive cycles. At most one strobe is issued per press/release cycle.

## Timing
- Reset values:
  - outputs: `col_o`=4'b1110 (column 0), `keyboard_val_o`=0, `key_pressed_o`=0, `key_strobe_o`=0.
  - internal: FSM in SCAN, divider 0, both counts 0, synchronizer flops 1.
- Reset mid-operation: asserting `reset_i` returns every register to its reset value immediately. This applies in all states, including mid-DEBOUNCE and HOLD.
- Synchronizer latency is 2 cycles. A row change must be stable at least 2 cycles before a sample edge to be seen at that sample.
- Press latency: the strobe asserts 1 cycle after the DEBOUNCE_CNT-th matching sample. The first detection to strobe is (DEBOUNCE_CNT-1)*SCAN_DIV+1 cycles.
- `keyboard_val_o` and `key_pressed_o` change in the same cycle that `key_strobe_o` rises.
- A column change takes effect on `col_o` in the cycle after its sample. Rows get the full dwell to settle before the next sample.
- Worst-case scan of all four columns is 4*SCAN_DIV cycles.

## Structure
- Shared package/header `keypad_defs` holds:
  - FSM state encodings (SCAN=2'd0, DEBOUNCE=2'd1, HOLD=2'd2);
  - default SCAN_DIV and DEBOUNCE_CNT;
  - the code-packing constant widths.
- One sub-module, `sync_2ff`: a generic N-bit two-flop synchronizer with async active-high reset value 1. It is instantiated for `row_i`.
- The divider, FSM and counters live in `keypad_scan` itself. Expected size is about 150-200 lines.

## Test plan
All scenarios use a bench with SCAN_DIV=4, DEBOUNCE_CNT=3 and a keypad model that pulls a row low when its key's column is driven low.
- Reset held, then released with no keys → `col_o` cycles 1110→1101→1011→0111→1110 every 4 cycles; strobe never asserts; val=0.
- Key row 2 / column 1 held → exactly one strobe 9 cycles after the first detecting sample; `keyboard_val_o`=4'h9; `key_pressed_o`=1; `col_o` frozen at 1101.
- Key pressed for 2 samples then released (bounce) → no strobe; `keyboard_val_o` unchanged; scanning resumes at the next column.
- Held key, release with a 1-sample re-bounce → `key_pressed_o` stays 1 until 3 consecutive no-hit samples, then falls; no second strobe.
- Rows 1 and 3 both low on column 3 → code 4'h7 (lowest row wins).
- Reset asserted mid-HOLD → all outputs return to reset values immediately; the next press strobes normally.
